// File: rtl/sram_mem_ctrl_if.sv
// Memory-stage bus: pipeline request/response plus the 16-bit SRAM pins.
interface sram_mem_ctrl_if;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SADDR_W = 18;
    localparam int unsigned SDQ_W   = 16;

    logic               mem_r_en;
    logic               mem_w_en;
    logic [DATA_W-1:0]  alu_res;
    logic [DATA_W-1:0]  st_val;
    logic [DATA_W-1:0]  rd_data;
    logic               ready;
    logic [SADDR_W-1:0] sram_addr;
    logic [SDQ_W-1:0]   sram_dq_out;
    logic [SDQ_W-1:0]   sram_dq_in;
    logic               sram_dq_oe;
    logic               sram_we_n;

    // Pipeline and SRAM device side
    modport master (
        output mem_r_en, mem_w_en, alu_res, st_val, sram_dq_in,
        input  rd_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    // Controller side
    modport slave (
        input  mem_r_en, mem_w_en, alu_res, st_val, sram_dq_in,
        output rd_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_mem_ctrl.sv
// Memory-stage controller: splits each 32-bit load/store into two timed
// 16-bit SRAM half-accesses and stalls the pipeline until both are done.
module sram_mem_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned MEM_BASE    = 1024
) (
    input  logic           clk,
    input  logic           rst,
    sram_mem_ctrl_if.slave bus
);
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned HALF_W  = 16;
    localparam int unsigned SADDR_W = 18;
    localparam int unsigned WORD_W  = 17;
    localparam int unsigned CNT_W   = 3;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;

    logic                op_wr;
    logic [WORD_W-1:0]   word_q;
    logic [DATA_W-1:0]   st_q;

    logic [DATA_W-1:0]   offs_c;
    logic                req_c;
    logic                last_c;
    logic                cur_wr_c;
    logic [WORD_W-1:0]   cur_word_c;
    logic [DATA_W-1:0]   cur_st_c;
    logic                unused_offs;

    logic [SADDR_W-1:0]  addr_q, addr_nxt;
    logic [HALF_W-1:0]   dqo_q, dqo_nxt;
    logic                oe_q, oe_nxt;
    logic                we_n_q, we_n_nxt;
    logic [DATA_W-1:0]   rd_q, rd_nxt;

    // Byte address to SRAM word; below-base addresses simply wrap
    assign offs_c      = bus.alu_res - 32'(MEM_BASE);
    assign unused_offs = ^{offs_c[DATA_W-1:WORD_W+2], offs_c[1:0]};
    assign req_c       = bus.mem_r_en | bus.mem_w_en;
    assign last_c      = (cnt == WAIT_LAST);

    // On the accepting edge the latches are not loaded yet, so use live inputs
    assign cur_wr_c   = (state == IDLE) ? bus.mem_w_en : op_wr;
    assign cur_word_c = (state == IDLE) ? offs_c[WORD_W+1:2] : word_q;
    assign cur_st_c   = (state == IDLE) ? bus.st_val : st_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (req_c)  state_nxt = LOW;
            LOW:  if (last_c) state_nxt = HIGH;
            HIGH: if (last_c) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state_nxt != state)
            cnt_nxt = '0;
        else if (state == LOW || state == HIGH)
            cnt_nxt = cnt + CNT_W'(1);
        else
            cnt_nxt = '0;
    end

    // Next values of the registered SRAM pins and load data
    always_comb begin
        addr_nxt = addr_q;
        dqo_nxt  = dqo_q;
        oe_nxt   = 1'b0;
        we_n_nxt = 1'b1;
        rd_nxt   = rd_q;
        unique case (state_nxt)
            LOW: begin
                addr_nxt = {cur_word_c, 1'b0};
                if (cur_wr_c) begin
                    dqo_nxt  = cur_st_c[HALF_W-1:0];
                    oe_nxt   = 1'b1;
                    we_n_nxt = 1'b0;
                end
            end
            HIGH: begin
                addr_nxt = {cur_word_c, 1'b1};
                if (cur_wr_c) begin
                    dqo_nxt  = cur_st_c[DATA_W-1:HALF_W];
                    oe_nxt   = 1'b1;
                    we_n_nxt = 1'b0;
                end
            end
            default: ;
        endcase
        if (!op_wr && last_c && state == LOW)
            rd_nxt[HALF_W-1:0] = bus.sram_dq_in;
        if (!op_wr && last_c && state == HIGH)
            rd_nxt[DATA_W-1:HALF_W] = bus.sram_dq_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_wr  <= 1'b0;
            word_q <= '0;
            st_q   <= '0;
        end else if (state == IDLE && req_c) begin
            op_wr  <= bus.mem_w_en;
            word_q <= offs_c[WORD_W+1:2];
            st_q   <= bus.st_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            dqo_q  <= '0;
            oe_q   <= 1'b0;
            we_n_q <= 1'b1;
            rd_q   <= '0;
        end else begin
            addr_q <= addr_nxt;
            dqo_q  <= dqo_nxt;
            oe_q   <= oe_nxt;
            we_n_q <= we_n_nxt;
            rd_q   <= rd_nxt;
        end
    end

    assign bus.sram_addr   = addr_q;
    assign bus.sram_dq_out = dqo_q;
    assign bus.sram_dq_oe  = oe_q;
    assign bus.sram_we_n   = we_n_q;
    assign bus.rd_data     = rd_q;
    assign bus.ready       = (state == DONE) || (state == IDLE && !req_c);
endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Scoreboard bench for sram_mem_ctrl: one instance with WAIT_CYCLES=1, one with 0.
module tb_sram_mem_ctrl;
    typedef struct {
        int          dut;
        logic [17:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        int          dut;
        longint      t;
        logic [31:0] rd;
    } done_t;

    logic        clk;
    logic        rst_a [2];
    logic        r_en  [2];
    logic        w_en  [2];
    logic [31:0] alu   [2];
    logic [31:0] st    [2];

    logic        rdy   [2];
    logic        we_n  [2];
    logic        oe    [2];
    logic [17:0] addr  [2];
    logic [15:0] dqo   [2];
    logic [31:0] rd    [2];
    logic        prev_rdy [2];

    wr_t   wq [$];
    done_t cq [$];
    int    n_cmp = 0;
    int    n_bad = 0;

    sram_mem_ctrl_if bus0 ();
    sram_mem_ctrl_if bus1 ();

    sram_mem_ctrl #(.WAIT_CYCLES(0), .MEM_BASE(1024)) dut0 (.clk(clk), .rst(rst_a[0]), .bus(bus0));
    sram_mem_ctrl #(.WAIT_CYCLES(1), .MEM_BASE(1024)) dut1 (.clk(clk), .rst(rst_a[1]), .bus(bus1));

    // Directed SRAM contents, keyed by full halfword address
    function automatic logic [15:0] sram_model(input logic [17:0] a);
        case (a)
            18'h00000: return 16'h1111;
            18'h00001: return 16'h2222;
            18'h00002: return 16'hBEEF;
            18'h00003: return 16'hDEAD;
            18'h00004: return 16'h4444;
            18'h00005: return 16'h5555;
            18'h3FFFE: return 16'hCAFE;
            18'h3FFFF: return 16'hF00D;
            default:   return 16'h0000;
        endcase
    endfunction

    assign bus0.mem_r_en   = r_en[0];
    assign bus0.mem_w_en   = w_en[0];
    assign bus0.alu_res    = alu[0];
    assign bus0.st_val     = st[0];
    assign bus0.sram_dq_in = sram_model(bus0.sram_addr);
    assign bus1.mem_r_en   = r_en[1];
    assign bus1.mem_w_en   = w_en[1];
    assign bus1.alu_res    = alu[1];
    assign bus1.st_val     = st[1];
    assign bus1.sram_dq_in = sram_model(bus1.sram_addr);

    assign rdy[0]  = bus0.ready;       assign rdy[1]  = bus1.ready;
    assign we_n[0] = bus0.sram_we_n;   assign we_n[1] = bus1.sram_we_n;
    assign oe[0]   = bus0.sram_dq_oe;  assign oe[1]   = bus1.sram_dq_oe;
    assign addr[0] = bus0.sram_addr;   assign addr[1] = bus1.sram_addr;
    assign dqo[0]  = bus0.sram_dq_out; assign dqo[1]  = bus1.sram_dq_out;
    assign rd[0]   = bus0.rd_data;     assign rd[1]   = bus1.rd_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Called one time unit after a rising edge; returns at the first cycle after DONE
    task automatic issue(input int d, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] s, input logic [17:0] lo_addr,
                         input logic [31:0] exp_rd);
        int    wc;
        wr_t   e;
        done_t c;
        wc = (d == 1) ? 1 : 0;
        if (w) begin
            for (int i = 0; i <= wc; i++) begin
                e.dut = d; e.addr = lo_addr; e.data = s[15:0];
                wq.push_back(e);
            end
            for (int i = 0; i <= wc; i++) begin
                e.dut = d; e.addr = lo_addr + 18'd1; e.data = s[31:16];
                wq.push_back(e);
            end
        end
        c.dut = d;
        c.t   = longint'($time) + 4 + longint'((2 * wc + 3) * 10);
        c.rd  = exp_rd;
        cq.push_back(c);
        r_en[d] = r; w_en[d] = w; alu[d] = a; st[d] = s;
        @(posedge clk); #1;
        r_en[d] = 1'b0; w_en[d] = 1'b0; alu[d] = 32'h5555_0000; st[d] = 32'hFFFF_FFFF;
        repeat (2 * wc + 3) @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected SRAM writes and access completions as the DUTs present them
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_a[d]) begin
                prev_rdy[d] = 1'b1;
            end else begin
                if (!we_n[d]) begin
                    if (wq.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_write dut%0d: got addr %h data %h expected no write",
                                 d, addr[d], dqo[d]);
                    end else begin
                        wr_t e;
                        e = wq.pop_front();
                        chk($sformatf("wr_addr dut%0d", d), 32'(addr[d]), 32'(e.addr));
                        chk($sformatf("wr_data dut%0d", d), 32'(dqo[d]), 32'(e.data));
                        chk($sformatf("wr_oe dut%0d", d), 32'(oe[d]), 32'd1);
                    end
                end else begin
                    chk($sformatf("oe_no_write dut%0d", d), 32'(oe[d]), 32'd0);
                end
                if (rdy[d] && !prev_rdy[d]) begin
                    if (cq.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_done dut%0d: got ready at %0t expected none", d, $time);
                    end else begin
                        done_t c;
                        c = cq.pop_front();
                        chk($sformatf("done_dut dut%0d", d), 32'(d), 32'(c.dut));
                        chk($sformatf("done_time dut%0d", d), 32'($time), 32'(c.t));
                        chk($sformatf("rd_data dut%0d", d), rd[d], c.rd);
                    end
                end
                prev_rdy[d] = rdy[d];
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_a[d] = 1'b1; r_en[d] = 1'b0; w_en[d] = 1'b0;
            alu[d] = 32'h0; st[d] = 32'h0; prev_rdy[d] = 1'b1;
        end
        #2;
        rst_a[0] = 1'b0; rst_a[1] = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_ready dut%0d", d), 32'(rdy[d]), 32'd1);
            chk($sformatf("rst_we_n dut%0d", d), 32'(we_n[d]), 32'd1);
            chk($sformatf("rst_oe dut%0d", d), 32'(oe[d]), 32'd0);
            chk($sformatf("rst_rd dut%0d", d), rd[d], 32'h0);
            chk($sformatf("rst_addr dut%0d", d), 32'(addr[d]), 32'h0);
            chk($sformatf("rst_dqo dut%0d", d), 32'(dqo[d]), 32'h0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_a[0] = 1'b1; rst_a[1] = 1'b1;

        // Idle: no request
        repeat (10) begin
            @(negedge clk);
            chk("idle_ready", 32'(rdy[1]), 32'd1);
            chk("idle_we_n", 32'(we_n[1]), 32'd1);
        end
        @(posedge clk); #1;

        // Store, load, store-wins-over-load, wrapped load below base
        issue(1, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 18'd2, 32'h0000_0000);
        issue(1, 1'b1, 1'b0, 32'd1028, 32'h0000_0000, 18'd2, 32'hDEADBEEF);
        issue(1, 1'b1, 1'b1, 32'd1024, 32'h12345678, 18'd0, 32'hDEADBEEF);
        issue(1, 1'b1, 1'b0, 32'd1020, 32'h0000_0000, 18'h3FFFE, 32'hF00DCAFE);
        repeat (3) @(posedge clk); #1;

        // Zero wait states, back-to-back loads
        issue(0, 1'b1, 1'b0, 32'd1024, 32'h0, 18'd0, 32'h22221111);
        issue(0, 1'b1, 1'b0, 32'd1032, 32'h0, 18'd4, 32'h55554444);
        repeat (3) @(posedge clk); #1;

        // Reset in the second HIGH cycle of a store
        begin
            wr_t e;
            e.dut = 1; e.addr = 18'd4; e.data = 16'hF00D; wq.push_back(e); wq.push_back(e);
            e.addr = 18'd5; e.data = 16'h0BAD; wq.push_back(e);
        end
        r_en[1] = 1'b0; w_en[1] = 1'b1; alu[1] = 32'd1032; st[1] = 32'h0BADF00D;
        @(posedge clk); #1;
        w_en[1] = 1'b0; alu[1] = 32'h5555_0000; st[1] = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        rst_a[1] = 1'b0;
        #1;
        chk("abort_we_n", 32'(we_n[1]), 32'd1);
        chk("abort_oe", 32'(oe[1]), 32'd0);
        @(posedge clk); #1;
        chk("abort_rd", rd[1], 32'h0);
        chk("abort_addr", 32'(addr[1]), 32'h0);
        chk("abort_dqo", 32'(dqo[1]), 32'h0);
        rst_a[1] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_ready", 32'(rdy[1]), 32'd1);
        end

        repeat (3) @(posedge clk);
        chk("writes_outstanding", 32'(wq.size()), 32'd0);
        chk("dones_outstanding", 32'(cq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sram_mem_ctrl.md
SRAM_MEM_CTRL -- requirements
Module: sram_mem_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, extra clock cycles each 16-bit SRAM half-access is held (legal range 0..7).
REQ-002 Parameter MEM_BASE, default 1024, byte address mapped to SRAM word 0.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 mem_r_en  input  1  load request from the execute-stage register (LDR).
REQ-006 mem_w_en  input  1  store request from the execute-stage register (STR).
REQ-007 alu_res  input  32  byte address, i.e. the ALU sum base+offset.
REQ-008 st_val  input  32  store data (Rd value).
REQ-009 rd_data  output  32  assembled load data.
REQ-010 ready  output  1  high when memory stage may advance; low freezes the pipeline.
REQ-011 sram_addr  output  18  SRAM halfword address.
REQ-012 sram_dq_out  output  16  SRAM write data.
REQ-013 sram_dq_in  input  16  SRAM read data.
REQ-014 sram_dq_oe  output  1  drive enable for sram_dq_out.
REQ-015 sram_we_n  output  1  SRAM write strobe, active low.

Function
REQ-016 The word address SHALL be word = (alu_res - MEM_BASE) >> 2, unsigned modulo 2^32; addresses below MEM_BASE wrap silently, with no error flag.
REQ-017 The low half SHALL use sram_addr = {word[16:0],1'b0} and the high half SHALL use {word[16:0],1'b1}.
REQ-018 The FSM SHALL have states IDLE, LOW, HIGH, DONE.
REQ-019 IDLE -> LOW SHALL occur when mem_r_en or mem_w_en is high.
   - On that transition the block SHALL latch the operation, the computed word address and st_val.
   - Otherwise the FSM SHALL stay in IDLE.
REQ-020 If mem_r_en and mem_w_en are both high, the block SHALL perform a write only.
REQ-021 LOW and HIGH SHALL each last exactly WAIT_CYCLES+1 cycles, counted by a 3-bit wait counter that is cleared on every state entry.
   - LOW -> HIGH SHALL occur when the count reaches WAIT_CYCLES.
   - HIGH -> DONE SHALL occur when the count reaches WAIT_CYCLES.
   - DONE -> IDLE SHALL occur unconditionally after one cycle.
REQ-022 During a write, in LOW and HIGH:
   - sram_dq_oe SHALL be 1 and sram_we_n SHALL be 0;
   - sram_dq_out SHALL be latched st_val[15:0] in LOW and st_val[31:16] in HIGH.
REQ-023 During a read, sram_dq_oe SHALL be 0 and sram_we_n SHALL be 1.
   - On the final LOW cycle edge, sram_dq_in SHALL be captured into rd_data[15:0].
   - On the final HIGH cycle edge, sram_dq_in SHALL be captured into rd_data[31:16].
REQ-024 In IDLE and DONE:
   - sram_we_n SHALL be 1 and sram_dq_oe SHALL be 0;
   - sram_addr and sram_dq_out SHALL hold their last values.
REQ-025 ready SHALL be combinational: 1 in DONE, 1 in IDLE with no request, else 0.
REQ-026 Latency: a request seen in IDLE at cycle 0 SHALL give ready=1 in cycle 2*WAIT_CYCLES+3 only.
REQ-027 A request present in the cycle after DONE SHALL be accepted as a new access, with ready=0 in that cycle.
REQ-028 rd_data SHALL hold its value until the next read's captures, and writes SHALL NOT modify it.
REQ-029 Input changes during LOW/HIGH/DONE SHALL be ignored.

Reset
REQ-030 While rst=0 the block SHALL hold these values:
   - state IDLE, wait counter 0;
   - rd_data 0, sram_addr 0, sram_dq_out 0;
   - sram_dq_oe 0, sram_we_n 1.
REQ-031 Reset asserted mid-access SHALL abort the access within the same cycle (sram_we_n 1 immediately), with no completion or ready pulse owed.
REQ-032 After rst rises, the first access SHALL start only on a clock edge that sees a request.

Verification (WAIT_CYCLES=1 unless stated)
REQ-033 Idle: no request -> ready=1, sram_we_n=1, sram_dq_oe=0 for 10 cycles.
REQ-034 Store 0xDEADBEEF to alu_res=1028 -> response:
   - sram_addr=2 with dq_out=0xBEEF, then sram_addr=3 with dq_out=0xDEAD;
   - we_n low 2 cycles each;
   - ready=1 only in cycle 5.
REQ-035 Load from 1028 with SRAM model returning 0xBEEF@2 and 0xDEAD@3 -> rd_data=0xDEADBEEF, ready=1 in cycle 5.
REQ-036 WAIT_CYCLES=0, back-to-back loads at 1024 then 1032 -> ready=1 in cycles 3 and 7, with sram_addr sequence 0,1,4,5.
REQ-037 rst=0 in the second HIGH cycle of a store -> sram_we_n=1 and dq_oe=0 immediately; after release, ready=1 with no request.
REQ-038 mem_r_en=mem_w_en=1 at 1024 with st_val 0x12345678 -> write of 0x5678/0x1234 to addresses 0/1, with rd_data unchanged.
